// File: rtl/me_frame_scheduler.sv
// ---------------------------------------------------------------------------
// me_frame_scheduler
//
// Steps the single motion-estimation core through every macroblock of one
// frame in raster order. The sequence for each block is as follows:
//   1. Present the block coordinates.
//   2. Pulse me_trigger.
//   3. Wait for me_done, or give up after TIMEOUT_CYCLES.
//   4. Capture the result and offer it on a valid/ready result port.
// The next block is not issued until the previous result has been taken.
//
// Optional feature macro: ME_STATS_EN
//   When defined, the block adds the per-frame statistics outputs
//   sad_total and zero_mv_cnt.
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   start             begin a frame (only looked at while idle)
//   abort             synchronous abort back to idle, highest priority
//   busy              frame in progress
//   frame_done        one-cycle pulse once the last result is accepted
//   timeout_err       sticky flag: some block timed out this frame
//   me_trigger        one-cycle start pulse to the ME core
//   me_blk_x/_y       coordinates of the block being processed
//   me_done           ME core finished (low while searching)
//   me_distance       best SAD from the core
//   me_vector_x/_y    best motion vector from the core (two's complement)
//   res_valid/ready   result handshake
//   res_data          {timeout, blk_y, blk_x, vec_y, vec_x, distance}
//   sad_total         (ME_STATS_EN) saturating sum of distances
//   zero_mv_cnt       (ME_STATS_EN) count of non-timeout (0,0) vectors
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module me_frame_scheduler #(
  parameter int MB_COLS        = 4,
  parameter int MB_ROWS        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic                                          abort,
  output logic                                          busy,
  output logic                                          frame_done,
  output logic                                          timeout_err,
  output logic                                          me_trigger,
  output logic [$clog2(MB_COLS)-1:0]                    me_blk_x,
  output logic [$clog2(MB_ROWS)-1:0]                    me_blk_y,
  input  logic                                          me_done,
  input  logic [7:0]                                    me_distance,
  input  logic [3:0]                                    me_vector_x,
  input  logic [3:0]                                    me_vector_y,
  output logic                                          res_valid,
  input  logic                                          res_ready,
`ifdef ME_STATS_EN
  output logic [15:0]                                   sad_total,
  output logic [$clog2(MB_COLS)+$clog2(MB_ROWS):0]      zero_mv_cnt,
`endif
  output logic [16+$clog2(MB_COLS)+$clog2(MB_ROWS):0]   res_data
);

  localparam int XW = $clog2(MB_COLS);
  localparam int YW = $clog2(MB_ROWS);
  localparam int RW = 17 + XW + YW;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [XW-1:0] X_LAST    = XW'(MB_COLS - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(MB_ROWS - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPT,
    ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            to_q, to_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            timeout_err_q, timeout_err_d;
  logic            res_valid_q, res_valid_d;
  logic [RW-1:0]   res_data_q, res_data_d;
  logic            handshake;

  assign handshake = res_valid_q & res_ready;

`ifdef ME_STATS_EN
  localparam int ZW = XW + YW + 1;
  logic [15:0]   sad_q, sad_d;
  logic [ZW-1:0] zmv_q, zmv_d;
  logic [7:0]    sad_add;
  logic [16:0]   sad_sum;

  // A timed-out block counts as the worst possible distance.
  assign sad_add = to_q ? 8'hFF : me_distance;
  assign sad_sum = {1'b0, sad_q} + {9'd0, sad_add};
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      wait_q        <= '0;
      to_q          <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
`ifdef ME_STATS_EN
      sad_q         <= '0;
      zmv_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wait_q        <= wait_d;
      to_q          <= to_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
`ifdef ME_STATS_EN
      sad_q         <= sad_d;
      zmv_q         <= zmv_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    wait_d        = wait_q;
    to_d          = to_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    me_trigger    = 1'b0;
`ifdef ME_STATS_EN
    sad_d         = sad_q;
    zmv_d         = zmv_q;
`endif

    // Clear first so that a capture in the same cycle still sets res_valid.
    if (handshake) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d           = '0;
          y_d           = '0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = ST_ISSUE;
`ifdef ME_STATS_EN
          sad_d         = '0;
          zmv_d         = '0;
`endif
        end
      end

      // The result register must be free, or be emptied this cycle, before
      // the next block is issued. Otherwise the capture could overwrite an
      // unread result.
      ST_ISSUE: begin
        if (!res_valid_q || handshake) begin
          me_trigger = 1'b1;
          wait_d     = '0;
          to_d       = 1'b0;
          state_d    = ST_WAIT;
        end
      end

      // me_done is ignored in the first wait cycle. The core still shows the
      // previous block's done there.
      ST_WAIT: begin
        if (wait_q != '0 && me_done) begin
          state_d = ST_CAPT;
        end else if (wait_q == WAIT_LAST) begin
          to_d    = 1'b1;
          state_d = ST_CAPT;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      ST_CAPT: begin
        res_valid_d = 1'b1;
        if (to_q) begin
          res_data_d    = {1'b1, y_q, x_q, 4'h0, 4'h0, 8'hFF};
          timeout_err_d = 1'b1;
        end else begin
          res_data_d = {1'b0, y_q, x_q, me_vector_y, me_vector_x, me_distance};
        end
`ifdef ME_STATS_EN
        sad_d = sad_sum[16] ? 16'hFFFF : sad_sum[15:0];
        if (!to_q && me_vector_x == 4'h0 && me_vector_y == 4'h0) begin
          zmv_d = zmv_q + ZW'(1);
        end
`endif
        if (x_q == X_LAST) begin
          x_d = '0;
          y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
        state_d = (x_q == X_LAST && y_q == Y_LAST) ? ST_DRAIN : ST_ISSUE;
      end

      ST_DRAIN: begin
        if (handshake) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a trigger or capture this cycle.
    if (abort) begin
      state_d      = ST_IDLE;
      x_d          = '0;
      y_d          = '0;
      wait_d       = '0;
      to_d         = 1'b0;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;
      res_valid_d  = 1'b0;
      me_trigger   = 1'b0;
    end
  end

  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;
  assign me_blk_x    = x_q;
  assign me_blk_y    = y_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
`ifdef ME_STATS_EN
  assign sad_total   = sad_q;
  assign zero_mv_cnt = zmv_q;
`endif

endmodule

// File: tb/tb_me_frame_scheduler.sv
`timescale 1ns/1ps

module tb_me_frame_scheduler;

   localparam int COLS = 4;
   localparam int NBLK = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        busy, frame_done, timeout_err, me_trigger;
   logic [1:0]  me_blk_x, me_blk_y;
   logic        me_done = 1'b0;
   logic [7:0]  me_distance = 8'h00;
   logic [3:0]  me_vector_x = 4'h0;
   logic [3:0]  me_vector_y = 4'h0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [20:0] res_data;
`ifdef ME_STATS_EN
   logic [15:0] sad_total;
   logic [4:0]  zero_mv_cnt;
`endif

   int assertCount = 0;
   int failCount = 0;
   int trigIdx = 0;
   int resIdx = 0;
   int frameDoneCnt = 0;
   int hangBlk = -1;
   int dataMode = 0;
   int coreCnt = 0;
   int coreBlk = 0;
   bit coreBusy = 1'b0;

   me_frame_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err),
      .me_trigger(me_trigger), .me_blk_x(me_blk_x), .me_blk_y(me_blk_y),
      .me_done(me_done), .me_distance(me_distance),
      .me_vector_x(me_vector_x), .me_vector_y(me_vector_y),
      .res_valid(res_valid), .res_ready(res_ready),
`ifdef ME_STATS_EN
      .sad_total(sad_total), .zero_mv_cnt(zero_mv_cnt),
`endif
      .res_data(res_data)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Counts one comparison and reports it if the observed value is wrong
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Data the emulated ME core reports for block b in the current data mode
   function automatic logic [7:0] coreDist(input int b);
      if (dataMode == 1) return 8'd200;
      if (b == 6) return 8'h3C;
      return 8'(32'h20 + b * 3);
   endfunction

   function automatic logic [3:0] coreVx(input int b);
      if (dataMode == 1) return (b == 0 || b == 5 || b == 10) ? 4'h0 : 4'h1;
      if (b == 6) return 4'hF;
      return 4'(b);
   endfunction

   function automatic logic [3:0] coreVy(input int b);
      if (dataMode == 1) return 4'h0;
      if (b == 6) return 4'h8;
      return 4'(15 - b);
   endfunction

   // Expected result word for the b-th block in raster order
   function automatic logic [20:0] expRes(input int b);
      logic [1:0] x;
      logic [1:0] y;
      x = 2'(b % COLS);
      y = 2'(b / COLS);
      if (b == hangBlk) return {1'b1, y, x, 4'h0, 4'h0, 8'hFF};
      return {1'b0, y, x, coreVy(b), coreVx(b), coreDist(b)};
   endfunction

   // Negedge monitor. It emulates the ME core with done arriving 4 cycles
   // after the trigger, unless the block hangs. It checks the trigger order,
   // every accepted result, and that a stalled result holds its value.
   always @(negedge clk) begin
      if (!rst_n) begin
         coreBusy = 1'b0;
         me_done = 1'b0;
      end else begin
         if (frame_done) frameDoneCnt++;
         if (res_valid && res_ready) begin
            checkOutput($sformatf("res_blk%0d", resIdx), 32'(res_data), 32'(expRes(resIdx)));
            if (resIdx == 6 && dataMode == 0)
               checkOutput("blk6_fields", 32'(res_data[15:0]), 32'h8F3C);
            resIdx++;
         end else if (res_valid && !res_ready) begin
            checkOutput("res_hold", 32'(res_data), 32'(expRes(resIdx)));
         end
         if (me_trigger) begin
            coreBlk = int'(me_blk_y) * COLS + int'(me_blk_x);
            checkOutput($sformatf("trig_blk%0d", trigIdx), 32'(coreBlk), 32'(trigIdx));
            trigIdx++;
            coreBusy = 1'b1;
            coreCnt = 0;
            me_done = 1'b0;
         end else if (coreBusy) begin
            coreCnt++;
            if (coreCnt == 4 && coreBlk != hangBlk) begin
               me_done = 1'b1;
               me_distance = coreDist(coreBlk);
               me_vector_x = coreVx(coreBlk);
               me_vector_y = coreVy(coreBlk);
               coreBusy = 1'b0;
            end
         end
      end
   end

   // Advances one clock, leaving the bench 1 ns after the rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drives start/abort for one cycle and sets the consumer's ready level
   task automatic applyStimulus(input logic s, input logic a, input logic r);
      start = s;
      abort = a;
      res_ready = r;
      stepCycle();
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Waits (bounded) until the frame_done count reaches target
   task automatic waitFrameDone(input int target, input int bound, input string tag);
      for (int i = 0; i < bound && frameDoneCnt < target; i++) stepCycle();
      checkOutput(tag, 32'(frameDoneCnt >= target), 32'd1);
   endtask

   task automatic newFrame(input int hang, input int mode);
      hangBlk = hang;
      dataMode = mode;
      resIdx = 0;
      trigIdx = 0;
   endtask

   initial begin
      // Reset values
      repeat (3) stepCycle();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_fdone", 32'(frame_done), 32'd0);
      checkOutput("rst_toerr", 32'(timeout_err), 32'd0);
      checkOutput("rst_trig", 32'(me_trigger), 32'd0);
      checkOutput("rst_blk", 32'({me_blk_y, me_blk_x}), 32'd0);
      checkOutput("rst_data", 32'(res_data), 32'd0);
      rst_n = 1'b1;
      stepCycle();

      // Frame 1: normal run with the consumer always ready. A second start
      // mid-frame must be ignored.
      newFrame(-1, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("f1_busy", 32'(busy), 32'd1);
      repeat (3) stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitFrameDone(1, 500, "f1_done");
      stepCycle();
      checkOutput("f1_busy_low", 32'(busy), 32'd0);
      checkOutput("f1_results", 32'(resIdx), 32'(NBLK));
      checkOutput("f1_triggers", 32'(trigIdx), 32'(NBLK));
      checkOutput("f1_toerr", 32'(timeout_err), 32'd0);
      repeat (3) stepCycle();
      checkOutput("f1_fdone_once", 32'(frameDoneCnt), 32'd1);

      // Frame 2: the consumer stalls the first result for 20 cycles
      newFrame(-1, 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50 && !res_valid; i++) stepCycle();
      checkOutput("f2_first_valid", 32'(res_valid), 32'd1);
      repeat (20) stepCycle();
      checkOutput("f2_no_trig", 32'(trigIdx), 32'd1);
      checkOutput("f2_still_valid", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      waitFrameDone(2, 500, "f2_done");
      checkOutput("f2_results", 32'(resIdx), 32'(NBLK));

      // Frame 3: the core never finishes block (x=1,y=2)
      newFrame(9, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitFrameDone(3, 3000, "f3_done");
      stepCycle();
      checkOutput("f3_toerr", 32'(timeout_err), 32'd1);
      checkOutput("f3_results", 32'(resIdx), 32'(NBLK));
      checkOutput("f3_busy_low", 32'(busy), 32'd0);

      // Frame 4: abort in the first WAIT cycle of block 5, then restart
      newFrame(-1, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("f4_toerr_clr", 32'(timeout_err), 32'd0);
      for (int i = 0; i < 200 && trigIdx < 6; i++) stepCycle();
      checkOutput("f4_reach_blk5", 32'(trigIdx), 32'd6);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_valid", 32'(res_valid), 32'd0);
      checkOutput("abort_blk", 32'({me_blk_y, me_blk_x}), 32'd0);
      repeat (8) stepCycle();
      checkOutput("abort_no_fdone", 32'(frameDoneCnt), 32'd3);
      checkOutput("abort_no_trig", 32'(trigIdx), 32'd6);
      newFrame(-1, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitFrameDone(4, 500, "f4_done");
      checkOutput("f4_results", 32'(resIdx), 32'(NBLK));

`ifdef ME_STATS_EN
      // Frame 5: every distance is 200, with zero vectors on three blocks
      newFrame(-1, 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitFrameDone(5, 500, "f5_done");
      stepCycle();
      checkOutput("stat_sad", 32'(sad_total), 32'h0C80);
      checkOutput("stat_zmv", 32'(zero_mv_cnt), 32'd3);
      dataMode = 0;
`endif

      // Asynchronous reset in the middle of a frame
      newFrame(-1, 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 100 && trigIdx < 3; i++) stepCycle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_blk", 32'({me_blk_y, me_blk_x}), 32'd0);
      checkOutput("arst_valid", 32'(res_valid), 32'd0);
      stepCycle();
      rst_n = 1'b1;
      stepCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
